// File: rtl/tisaradc_deser_pkg.sv
// rtl/tisaradc_deser_pkg.sv - shared constants, FSM state type and lane helpers
// Contents: ADC_WAYS, ADC_BITS, WORD_W, state_e {IDLE, FLUSH, RUN},
//           lane_slice(word, k), ob_to_tc(code)
package tisaradc_pkg;

  localparam int ADC_WAYS = 8;
  localparam int ADC_BITS = 9;
  localparam int WORD_W   = ADC_WAYS * ADC_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Lane k occupies bits [ADC_BITS*k +: ADC_BITS] of a packed word.
  function automatic logic [ADC_BITS-1:0] lane_slice(input logic [WORD_W-1:0] word,
                                                     input int k);
    return word[k*ADC_BITS +: ADC_BITS];
  endfunction

  // Offset binary to two's complement is just an MSB inversion.
  function automatic logic [ADC_BITS-1:0] ob_to_tc(input logic [ADC_BITS-1:0] code);
    return {~code[ADC_BITS-1], code[ADC_BITS-2:0]};
  endfunction

endpackage

// File: rtl/tisaradc_deser_if.sv
// rtl/tisaradc_deser_if.sv - valid/ready output stream toward the DSP chain
// Signals: out_valid (head valid), out_ready (consumer accepts), out_data (W bits)
// Modports: master (producer side), slave (consumer side)
interface tisaradc_deser_if
  import tisaradc_pkg::*;
#(
  parameter int W = WORD_W
);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/tisaradc_deser_sync_fifo.sv
// rtl/tisaradc_deser_sync_fifo.sv - synchronous FIFO, async active-high reset
// Ports: clock, reset, push/push_data (caller guarantees room or a same-cycle
//        pop), pop (caller guarantees not empty), pop_data (head, combinational
//        from storage), full, empty, level (0..DEPTH)
module tisaradc_sync_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Storage is cleared on reset too, so no stale word can reappear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;

endmodule

// File: rtl/tisaradc_deser.sv
// rtl/tisaradc_deser.sv - TI-SAR ADC capture, offset-binary to 2's complement, FIFO
// Ports: clock, reset (async, active-high), adc_in[71:0], enable,
//        out_if (master: out_valid/out_ready/out_data), running, fifo_level,
//        overflow_cnt, ovf_clr, sat_flags
// Optional: TISARADC_DESER_SATMON_EN builds the per-lane sticky saturation monitor.
module tisaradc_deser
  import tisaradc_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [WORD_W-1:0]           adc_in,
  input  logic                        enable,
  tisaradc_deser_if.master            out_if,
  output logic                        running,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            overflow_cnt,
  input  logic                        ovf_clr,
  output logic [ADC_WAYS-1:0]         sat_flags
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  state_e               state_q, state_d;
  logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [WORD_W-1:0]    capture_q, capture_d;
  logic [WORD_W-1:0]    conv_q, conv_d;
  logic                 conv_valid_q, conv_valid_d;
  logic [CNT_W-1:0]     ovf_cnt_q, ovf_cnt_d;
  logic                 fifo_full, fifo_empty;
  logic                 pop, push_ok, drop;

  // State register and datapath flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      flush_cnt_q  <= '0;
      capture_q    <= '0;
      conv_q       <= '0;
      conv_valid_q <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      capture_q    <= capture_d;
      conv_q       <= conv_d;
      conv_valid_q <= conv_valid_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: if (enable) state_d = FLUSH;
      FLUSH: begin
        if (!enable) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
        end else if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FW'(1);
        end
      end
      RUN: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    running = (state_q == RUN);
  end

  // Capture is unconditional; the conversion stage is tagged valid only for
  // samples captured while in RUN, so the first word is the RUN-entry sample
  // and a sample captured on the last RUN cycle still lands in the FIFO.
  always_comb begin
    capture_d    = adc_in;
    conv_d       = '0;
    for (int k = 0; k < ADC_WAYS; k++) begin
      conv_d[k*ADC_BITS +: ADC_BITS] = ob_to_tc(lane_slice(capture_q, k));
    end
    conv_valid_d = (state_q == RUN);
  end

  assign pop     = out_if.out_valid && out_if.out_ready;
  assign push_ok = conv_valid_q && (!fifo_full || pop);
  assign drop    = conv_valid_q && !push_ok;

  // Clear wins over a same-cycle drop; count saturates at all-ones.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (drop && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  tisaradc_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_ok),
    .push_data (conv_q),
    .pop       (pop),
    .pop_data  (out_if.out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_if.out_valid = !fifo_empty;
  assign overflow_cnt     = ovf_cnt_q;

`ifdef TISARADC_DESER_SATMON_EN
  logic [ADC_WAYS-1:0] sat_q, sat_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sat_q <= '0;
    else       sat_q <= sat_d;
  end

  // Raw offset-binary rail codes are all-zeros and all-ones.
  always_comb begin
    sat_d = sat_q;
    if (ovf_clr) begin
      sat_d = '0;
    end else if (state_q == RUN) begin
      for (int k = 0; k < ADC_WAYS; k++) begin
        if ((lane_slice(capture_q, k) == '0) || (lane_slice(capture_q, k) == '1)) begin
          sat_d[k] = 1'b1;
        end
      end
    end
  end

  assign sat_flags = sat_q;
`else
  assign sat_flags = '0;
`endif

endmodule
